// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared widths, ALU encodings and control bundle for the ID/EX stage
package id_ex_stage_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int REG_AW_DEF  = 3;
    localparam int ALUOP_W_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    // Control bundle carried alongside each instruction: RegWrite, MemRead, MemWrite
    localparam int CTRL_W = 3;

    typedef enum logic [ALUOP_W_DEF-1:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_AND    = 4'h2,
        ALU_OR     = 4'h3,
        ALU_XOR    = 4'h4,
        ALU_SLL    = 4'h5,
        ALU_SRL    = 4'h6,
        ALU_SLT    = 4'h7,
        ALU_PASS_B = 4'h8
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    // A bubble carries no side effects: no register write, no memory access
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection and stall generation
module hazard_detect #(
    parameter int REG_AW = 3
)(
    input  logic              x_valid,
    input  logic              x_mem_read,
    input  logic              x_reg_write,
    input  logic [REG_AW-1:0] x_rd,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic              d_uses_rs,
    input  logic              d_uses_rt,
    input  logic              flush,
    input  logic              hold,
    output logic              load_use,
    output logic              stall
);

    logic rs_match;
    logic rt_match;

    // A load in X whose result a real decode instruction needs cannot be forwarded in time
    always_comb begin
        rs_match = d_uses_rs && (d_rs == x_rd);
        rt_match = d_uses_rt && (d_rt == x_rd);
        load_use = x_valid && x_mem_read && x_reg_write && d_valid && (rs_match || rt_match);
        // Flush discards the dependent instruction anyway; Hold already freezes everything
        stall    = load_use && !flush && !hold;
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubbling and write-through bypass
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               DValid,
    input  logic [REG_AW-1:0]  DRs,
    input  logic [REG_AW-1:0]  DRt,
    input  logic [REG_AW-1:0]  DRd,
    input  logic               DUsesRs,
    input  logic               DUsesRt,
    input  logic [DATA_W-1:0]  DRegVal1,
    input  logic [DATA_W-1:0]  DRegVal2,
    input  logic [DATA_W-1:0]  DImm,
    input  logic [DATA_W-1:0]  DPC,
    input  logic               DRegWrite,
    input  logic               DMemRead,
    input  logic               DMemWrite,
    input  logic [ALUOP_W-1:0] DAluOp,
    input  logic               WRegWrite,
    input  logic [REG_AW-1:0]  WRd,
    input  logic [DATA_W-1:0]  WRegVal,
    input  logic               Flush,
    input  logic               Hold,
    output logic               XValid,
    output logic [REG_AW-1:0]  XRs,
    output logic [REG_AW-1:0]  XRt,
    output logic [REG_AW-1:0]  XRd,
    output logic [DATA_W-1:0]  XRegVal1,
    output logic [DATA_W-1:0]  XRegVal2,
    output logic [DATA_W-1:0]  XImm,
    output logic [DATA_W-1:0]  XPC,
    output logic               XRegWrite,
    output logic               XMemRead,
    output logic               XMemWrite,
    output logic [ALUOP_W-1:0] XAluOp,
    output logic               Stall,
    output logic [CNT_W-1:0]   StallCount
);

    logic               valid_q, valid_d;
    logic [REG_AW-1:0]  rs_q, rs_d;
    logic [REG_AW-1:0]  rt_q, rt_d;
    logic [REG_AW-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0]  reg_val1_q, reg_val1_d;
    logic [DATA_W-1:0]  reg_val2_q, reg_val2_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;

    logic [DATA_W-1:0]  bval1;
    logic [DATA_W-1:0]  bval2;
    logic               load_use;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .x_valid     (valid_q),
        .x_mem_read  (ctrl_q.mem_read),
        .x_reg_write (ctrl_q.reg_write),
        .x_rd        (rd_q),
        .d_valid     (DValid),
        .d_rs        (DRs),
        .d_rt        (DRt),
        .d_uses_rs   (DUsesRs),
        .d_uses_rt   (DUsesRt),
        .flush       (Flush),
        .hold        (Hold),
        .load_use    (load_use),
        .stall       (Stall)
    );

    // Register-file write-through: a same-cycle writeback overrides the stale read data
    always_comb begin
        bval1 = DRegVal1;
        bval2 = DRegVal2;
        if (WRegWrite && (WRd == DRs)) begin
            bval1 = WRegVal;
        end
        if (WRegWrite && (WRd == DRt)) begin
            bval2 = WRegVal;
        end
    end

    // Next-state: Hold freezes, otherwise capture with Flush/load-use turning it into a bubble
    always_comb begin
        valid_d       = valid_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        rd_d          = rd_q;
        reg_val1_d    = reg_val1_q;
        reg_val2_d    = reg_val2_q;
        imm_d         = imm_q;
        pc_d          = pc_q;
        ctrl_d        = ctrl_q;
        alu_op_d      = alu_op_q;
        stall_count_d = stall_count_q;
        if (!Hold) begin
            // Data fields always follow decode; a bubble makes them inert via its controls
            rs_d       = DRs;
            rt_d       = DRt;
            rd_d       = DRd;
            reg_val1_d = bval1;
            reg_val2_d = bval2;
            imm_d      = DImm;
            pc_d       = DPC;
            alu_op_d   = DAluOp;
            if (Flush || load_use) begin
                valid_d = 1'b0;
                ctrl_d  = CTRL_BUBBLE;
            end else begin
                valid_d          = DValid;
                ctrl_d.reg_write = DRegWrite;
                ctrl_d.mem_read  = DMemRead;
                ctrl_d.mem_write = DMemWrite;
            end
            if (!Flush && load_use && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    // Pipeline register state, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            reg_val1_q    <= '0;
            reg_val2_q    <= '0;
            imm_q         <= '0;
            pc_q          <= '0;
            ctrl_q        <= CTRL_BUBBLE;
            alu_op_q      <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            reg_val1_q    <= reg_val1_d;
            reg_val2_q    <= reg_val2_d;
            imm_q         <= imm_d;
            pc_q          <= pc_d;
            ctrl_q        <= ctrl_d;
            alu_op_q      <= alu_op_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign XValid     = valid_q;
    assign XRs        = rs_q;
    assign XRt        = rt_q;
    assign XRd        = rd_q;
    assign XRegVal1   = reg_val1_q;
    assign XRegVal2   = reg_val2_q;
    assign XImm       = imm_q;
    assign XPC        = pc_q;
    assign XRegWrite  = ctrl_q.reg_write;
    assign XMemRead   = ctrl_q.mem_read;
    assign XMemWrite  = ctrl_q.mem_write;
    assign XAluOp     = alu_op_q;
    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    localparam int SCW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        DValid, DUsesRs, DUsesRt, DRegWrite, DMemRead, DMemWrite;
    logic [2:0]  DRs, DRt, DRd, WRd;
    logic [15:0] DRegVal1, DRegVal2, DImm, DPC, WRegVal;
    logic [3:0]  DAluOp;
    logic        WRegWrite, Flush, Hold;

    logic        XValid, XRegWrite, XMemRead, XMemWrite, Stall;
    logic [2:0]  XRs, XRt, XRd;
    logic [15:0] XRegVal1, XRegVal2, XImm, XPC, StallCount;
    logic [3:0]  XAluOp;

    logic        s_XValid, s_XRegWrite, s_XMemRead, s_XMemWrite, s_Stall;
    logic [2:0]  s_XRs, s_XRt, s_XRd;
    logic [15:0] s_XRegVal1, s_XRegVal2, s_XImm, s_XPC;
    logic [3:0]  s_XAluOp;
    logic [SCW-1:0] s_StallCount;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .DValid(DValid), .DRs(DRs), .DRt(DRt), .DRd(DRd),
        .DUsesRs(DUsesRs), .DUsesRt(DUsesRt), .DRegVal1(DRegVal1), .DRegVal2(DRegVal2),
        .DImm(DImm), .DPC(DPC), .DRegWrite(DRegWrite), .DMemRead(DMemRead),
        .DMemWrite(DMemWrite), .DAluOp(DAluOp), .WRegWrite(WRegWrite), .WRd(WRd),
        .WRegVal(WRegVal), .Flush(Flush), .Hold(Hold), .XValid(XValid), .XRs(XRs),
        .XRt(XRt), .XRd(XRd), .XRegVal1(XRegVal1), .XRegVal2(XRegVal2), .XImm(XImm),
        .XPC(XPC), .XRegWrite(XRegWrite), .XMemRead(XMemRead), .XMemWrite(XMemWrite),
        .XAluOp(XAluOp), .Stall(Stall), .StallCount(StallCount)
    );

    // Narrow-counter instance sharing all inputs, used to reach saturation quickly
    id_ex_stage #(.CNT_W(SCW)) dut_sat (
        .clk(clk), .rst(rst), .DValid(DValid), .DRs(DRs), .DRt(DRt), .DRd(DRd),
        .DUsesRs(DUsesRs), .DUsesRt(DUsesRt), .DRegVal1(DRegVal1), .DRegVal2(DRegVal2),
        .DImm(DImm), .DPC(DPC), .DRegWrite(DRegWrite), .DMemRead(DMemRead),
        .DMemWrite(DMemWrite), .DAluOp(DAluOp), .WRegWrite(WRegWrite), .WRd(WRd),
        .WRegVal(WRegVal), .Flush(Flush), .Hold(Hold), .XValid(s_XValid), .XRs(s_XRs),
        .XRt(s_XRt), .XRd(s_XRd), .XRegVal1(s_XRegVal1), .XRegVal2(s_XRegVal2), .XImm(s_XImm),
        .XPC(s_XPC), .XRegWrite(s_XRegWrite), .XMemRead(s_XMemRead), .XMemWrite(s_XMemWrite),
        .XAluOp(s_XAluOp), .Stall(s_Stall), .StallCount(s_StallCount)
    );

    typedef struct {
        logic        dv;
        logic [2:0]  rs, rt, rd;
        logic        urs, urt;
        logic [15:0] v1, v2;
        logic        regw, memr, memw;
        logic [3:0]  alu;
        logic        wregw;
        logic [2:0]  wrd;
        logic [15:0] wval;
        logic        flush;
        logic        e_stall, e_xv;
        logic [2:0]  e_rs, e_rt, e_rd;
        logic [15:0] e_v1, e_v2;
        logic        e_regw, e_memr, e_memw;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mkv(
        input logic dv, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
        input logic urs, input logic urt, input logic [15:0] v1, input logic [15:0] v2,
        input logic regw, input logic memr, input logic memw, input logic [3:0] alu,
        input logic wregw, input logic [2:0] wrd, input logic [15:0] wval, input logic flush,
        input logic e_stall, input logic e_xv, input logic [2:0] e_rs, input logic [2:0] e_rt,
        input logic [2:0] e_rd, input logic [15:0] e_v1, input logic [15:0] e_v2,
        input logic e_regw, input logic e_memr, input logic e_memw, input logic [15:0] e_cnt);
        vec_t v;
        v.dv = dv; v.rs = rs; v.rt = rt; v.rd = rd; v.urs = urs; v.urt = urt;
        v.v1 = v1; v.v2 = v2; v.regw = regw; v.memr = memr; v.memw = memw; v.alu = alu;
        v.wregw = wregw; v.wrd = wrd; v.wval = wval; v.flush = flush;
        v.e_stall = e_stall; v.e_xv = e_xv; v.e_rs = e_rs; v.e_rt = e_rt; v.e_rd = e_rd;
        v.e_v1 = e_v1; v.e_v2 = e_v2; v.e_regw = e_regw; v.e_memr = e_memr; v.e_memw = e_memw;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [15:0] pc);
        DValid = v.dv; DRs = v.rs; DRt = v.rt; DRd = v.rd; DUsesRs = v.urs; DUsesRt = v.urt;
        DRegVal1 = v.v1; DRegVal2 = v.v2; DImm = v.v1 ^ 16'hA5A5; DPC = pc;
        DRegWrite = v.regw; DMemRead = v.memr; DMemWrite = v.memw; DAluOp = v.alu;
        WRegWrite = v.wregw; WRd = v.wrd; WRegVal = v.wval; Flush = v.flush; Hold = 1'b0;
    endtask

    task automatic apply_vec(input string tag, input vec_t v, input logic [15:0] pc);
        logic [15:0] sat;
        @(negedge clk);
        drive(v, pc);
        #1;
        chk({tag, ".stall"}, Stall, v.e_stall);
        @(posedge clk);
        #1;
        sat = (v.e_cnt > 16'd3) ? 16'd3 : v.e_cnt;
        chk({tag, ".xvalid"}, XValid, v.e_xv);
        chk({tag, ".xrs"}, XRs, v.e_rs);
        chk({tag, ".xrt"}, XRt, v.e_rt);
        chk({tag, ".xrd"}, XRd, v.e_rd);
        chk({tag, ".xregval1"}, XRegVal1, v.e_v1);
        chk({tag, ".xregval2"}, XRegVal2, v.e_v2);
        chk({tag, ".ximm"}, XImm, v.v1 ^ 16'hA5A5);
        chk({tag, ".xpc"}, XPC, pc);
        chk({tag, ".xaluop"}, XAluOp, v.alu);
        chk({tag, ".xregwrite"}, XRegWrite, v.e_regw);
        chk({tag, ".xmemread"}, XMemRead, v.e_memr);
        chk({tag, ".xmemwrite"}, XMemWrite, v.e_memw);
        chk({tag, ".stallcount"}, StallCount, v.e_cnt);
        chk({tag, ".stallcount_sat"}, 32'(s_StallCount), sat);
    endtask

    initial begin
        vec_t ld, dep;

        tbl[0]  = mkv(1,1,0,3,1,0,16'h1234,16'h0000,1,0,0,4'h3, 0,0,16'h0,0, 0,1,1,0,3,16'h1234,16'h0000,1,0,0,0);
        tbl[1]  = mkv(1,1,0,2,1,0,16'h0010,16'h0000,1,1,0,4'h0, 0,0,16'h0,0, 0,1,1,0,2,16'h0010,16'h0000,1,1,0,0);
        tbl[2]  = mkv(1,3,2,4,1,1,16'h0005,16'h0006,1,0,0,4'h1, 0,0,16'h0,0, 1,0,3,2,4,16'h0005,16'h0006,0,0,0,1);
        tbl[3]  = mkv(1,3,2,4,1,1,16'h0005,16'h0006,1,0,0,4'h1, 1,2,16'hBEEF,0, 0,1,3,2,4,16'h0005,16'hBEEF,1,0,0,1);
        tbl[4]  = mkv(1,5,5,1,1,1,16'h0000,16'h0000,1,0,0,4'h2, 1,5,16'hBEEF,0, 0,1,5,5,1,16'hBEEF,16'hBEEF,1,0,0,1);
        tbl[5]  = mkv(1,5,5,1,1,1,16'h0000,16'h0000,1,0,0,4'h2, 0,5,16'hBEEF,0, 0,1,5,5,1,16'h0000,16'h0000,1,0,0,1);
        tbl[6]  = mkv(1,5,6,0,1,1,16'h0000,16'h0000,0,0,1,4'h0, 0,0,16'h0,0, 0,1,5,6,0,16'h0000,16'h0000,0,0,1,1);
        tbl[7]  = mkv(1,0,0,6,1,0,16'h0000,16'h0000,1,1,0,4'h0, 0,0,16'h0,0, 0,1,0,0,6,16'h0000,16'h0000,1,1,0,1);
        tbl[8]  = mkv(1,6,0,3,1,0,16'h0007,16'h0000,1,0,0,4'h4, 0,0,16'h0,1, 0,0,6,0,3,16'h0007,16'h0000,0,0,0,1);
        tbl[9]  = mkv(1,0,0,7,0,0,16'h0000,16'h0000,1,1,0,4'h0, 0,0,16'h0,0, 0,1,0,0,7,16'h0000,16'h0000,1,1,0,1);
        tbl[10] = mkv(1,7,0,1,1,0,16'h0011,16'h0000,1,1,0,4'h0, 0,0,16'h0,0, 1,0,7,0,1,16'h0011,16'h0000,0,0,0,2);
        tbl[11] = mkv(1,7,0,1,1,0,16'h0011,16'h0000,1,1,0,4'h0, 0,0,16'h0,0, 0,1,7,0,1,16'h0011,16'h0000,1,1,0,2);
        tbl[12] = mkv(1,7,1,5,1,1,16'h0000,16'h0022,1,0,0,4'h1, 0,0,16'h0,0, 1,0,7,1,5,16'h0000,16'h0022,0,0,0,3);
        tbl[13] = mkv(1,7,1,5,1,1,16'h0000,16'h0022,1,0,0,4'h1, 0,0,16'h0,0, 0,1,7,1,5,16'h0000,16'h0022,1,0,0,3);
        tbl[14] = mkv(1,0,0,4,0,0,16'h0000,16'h0000,1,1,0,4'h0, 0,0,16'h0,0, 0,1,0,0,4,16'h0000,16'h0000,1,1,0,3);
        tbl[15] = mkv(1,4,4,2,0,0,16'h0033,16'h0044,1,0,0,4'h1, 0,0,16'h0,0, 0,1,4,4,2,16'h0033,16'h0044,1,0,0,3);
        tbl[16] = mkv(1,0,0,2,0,0,16'h0000,16'h0000,1,1,0,4'h0, 0,0,16'h0,0, 0,1,0,0,2,16'h0000,16'h0000,1,1,0,3);
        tbl[17] = mkv(0,2,0,0,1,0,16'h0000,16'h0000,0,0,0,4'h0, 0,0,16'h0,0, 0,0,2,0,0,16'h0000,16'h0000,0,0,0,3);
        tbl[18] = mkv(1,0,0,3,0,0,16'h0000,16'h0000,1,1,0,4'h0, 0,0,16'h0,0, 0,1,0,0,3,16'h0000,16'h0000,1,1,0,3);
        tbl[19] = mkv(1,3,0,0,1,0,16'h0000,16'h0000,1,0,0,4'h0, 0,0,16'h0,0, 1,0,3,0,0,16'h0000,16'h0000,0,0,0,4);

        rst = 1'b1;
        drive(mkv(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0), 16'h0);
        #2;
        chk("reset.xvalid", XValid, 1'b0);
        chk("reset.xmemread", XMemRead, 1'b0);
        chk("reset.xregval1", XRegVal1, 16'h0);
        chk("reset.stallcount", StallCount, 16'h0);
        chk("reset.stall", Stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            apply_vec($sformatf("vec%0d", i), tbl[i], 16'(2 * i + 2));
        end

        // Hold with Flush and a live hazard: everything frozen, no stall
        ld  = mkv(1,0,0,2,0,0,16'h0abc,16'h0000,1,1,0,4'h0, 0,0,16'h0,0, 0,1,0,0,2,16'h0abc,16'h0000,1,1,0,4);
        apply_vec("hold.load", ld, 16'h0100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dep = mkv(1,2,2,k[2:0],1,1,16'h1000 + 16'(k),16'h2000,1,0,1,4'h5, 1,2,16'h7777,1,
                      0,0,0,0,0,0,0,0,0,0,0);
            drive(dep, 16'h0200 + 16'(k));
            Hold = 1'b1;
            #1;
            chk($sformatf("hold%0d.stall", k), Stall, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d.xvalid", k), XValid, 1'b1);
            chk($sformatf("hold%0d.xrd", k), XRd, 3'd2);
            chk($sformatf("hold%0d.xmemread", k), XMemRead, 1'b1);
            chk($sformatf("hold%0d.xregval1", k), XRegVal1, 16'h0abc);
            chk($sformatf("hold%0d.xpc", k), XPC, 16'h0100);
            chk($sformatf("hold%0d.stallcount", k), StallCount, 16'd4);
        end
        @(negedge clk);
        Hold = 1'b0;
        #1;
        chk("unhold.stall", Stall, 1'b0);
        @(posedge clk);
        #1;
        chk("unhold.xvalid", XValid, 1'b0);
        chk("unhold.xmemread", XMemRead, 1'b0);
        chk("unhold.xmemwrite", XMemWrite, 1'b0);
        chk("unhold.xrs", XRs, 3'd2);
        chk("unhold.stallcount", StallCount, 16'd4);

        // Async reset between edges during a load-use stall
        ld = mkv(1,0,0,5,0,0,16'h0000,16'h0000,1,1,0,4'h0, 0,0,16'h0,0, 0,1,0,0,5,16'h0000,16'h0000,1,1,0,4);
        apply_vec("rst.load", ld, 16'h0300);
        @(negedge clk);
        dep = mkv(1,5,0,6,1,0,16'h0055,16'h0000,1,0,0,4'h2, 0,0,16'h0,0, 0,0,0,0,0,0,0,0,0,0,0);
        drive(dep, 16'h0302);
        #1;
        chk("rst.pre_stall", Stall, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst.xvalid", XValid, 1'b0);
        chk("rst.xrd", XRd, 3'd0);
        chk("rst.xmemread", XMemRead, 1'b0);
        chk("rst.xregwrite", XRegWrite, 1'b0);
        chk("rst.stallcount", StallCount, 16'd0);
        chk("rst.stallcount_sat", 32'(s_StallCount), 32'd0);
        chk("rst.stall", Stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.xvalid", XValid, 1'b1);
        chk("post_rst.xrs", XRs, 3'd5);
        chk("post_rst.xregval1", XRegVal1, 16'h0055);
        chk("post_rst.stallcount", StallCount, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
